// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract sequencer around an external 4-bit nibble adder.
// One nibble pair per cycle, LSB first; flags are latched on the last nibble.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [3:0]       nib_x,
  output logic [3:0]       nib_y,
  output logic             nib_cin,
  input  logic [3:0]       nib_s,
  input  logic             nib_cout
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, w_a_next;
  logic [WIDTH-1:0] r_b, w_b_next;
  logic [WIDTH-1:0] r_res, w_res_next, w_res_merged;
  logic             r_carry, w_carry_next;
  logic [IW-1:0]    r_idx, w_idx_next;
  logic             r_cout, w_cout_next;
  logic             r_ovf, w_ovf_next;
  logic             r_zero, w_zero_next;
  logic             r_neg, w_neg_next;

  // Result as it will look once the current nibble is written.
  always_comb begin
    w_res_merged = r_res;
    w_res_merged[4*r_idx +: 4] = nib_s;
  end

  // Next-state logic; abort overrides everything and freezes result and flags.
  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_res_next   = r_res;
    w_carry_next = r_carry;
    w_idx_next   = r_idx;
    w_cout_next  = r_cout;
    w_ovf_next   = r_ovf;
    w_zero_next  = r_zero;
    w_neg_next   = r_neg;
    if (abort) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            w_a_next     = a;
            w_b_next     = sub ? ~b : b;
            w_carry_next = sub;
            w_idx_next   = '0;
            w_state_next = StRun;
          end
        end
        StRun: begin
          w_res_next   = w_res_merged;
          w_carry_next = nib_cout;
          if (r_idx == LastIdx) begin
            // idx stays at N-1 rather than wrapping; reloaded on accept.
            w_cout_next  = nib_cout;
            w_neg_next   = nib_s[3];
            w_ovf_next   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (nib_s[3] != r_a[WIDTH-1]);
            w_zero_next  = (w_res_merged == '0);
            w_state_next = StDone;
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            w_state_next = StIdle;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Outputs; the adder inputs are forced to zero outside RUN.
  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
    result    = r_res;
    cout      = r_cout;
    ovf       = r_ovf;
    zero      = r_zero;
    neg       = r_neg;
    nib_x     = 4'h0;
    nib_y     = 4'h0;
    nib_cin   = 1'b0;
    if (r_state == StRun) begin
      nib_x   = r_a[4*r_idx +: 4];
      nib_y   = r_b[4*r_idx +: 4];
      nib_cin = r_carry;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_res   <= w_res_next;
      r_carry <= w_carry_next;
      r_idx   <= w_idx_next;
      r_cout  <= w_cout_next;
      r_ovf   <= w_ovf_next;
      r_zero  <= w_zero_next;
      r_neg   <= w_neg_next;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=32) with a behavioural nibble adder.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;
  logic [3:0]  nib_x;
  logic [3:0]  nib_y;
  logic        nib_cin;
  logic [3:0]  nib_s;
  logic        nib_cout;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  // External 4-bit adder, purely combinational.
  assign {nib_cout, nib_s} = {1'b0, nib_x} + {1'b0, nib_y} + {4'b0, nib_cin};

  nibble_serial_adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg),
    .nib_x     (nib_x),
    .nib_y     (nib_y),
    .nib_cin   (nib_cin),
    .nib_s     (nib_s),
    .nib_cout  (nib_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flags packed as {cout, ovf, zero, neg}.
  function automatic logic [31:0] flags();
    return {28'd0, cout, ovf, zero, neg};
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Issue one operation, check latency, result and flags, then take the result.
  task automatic run_op(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                        input logic s, input logic [31:0] exp_res, input logic [3:0] exp_flags);
    int n;
    a = opa; b = opb; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    wait_done(n);
    chk({tag, "_lat"}, n, 32'd8);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_flg"}, flags(), {28'd0, exp_flags});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hs", {30'd0, in_ready, out_valid}, 32'd2);
    chk("rst_res", result, 32'd0);
    chk("rst_flg", flags(), 32'd0);
    chk("rst_nib", {23'd0, nib_x, nib_y, nib_cin}, 32'd0);
    rst = 1'b0;
    tick();

    // Flags order {cout, ovf, zero, neg}.
    run_op("ripple", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 4'b0000);
    run_op("sovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0101);
    run_op("wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b1010);

    // Abort at idx=3: no result, flags from the previous op (cout=1, zero=1) kept.
    a = 32'h11111111; b = 32'h22222222; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("abt_nib", {23'd0, nib_x, nib_y, nib_cin}, {23'd0, 4'h1, 4'h2, 1'b0});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_hs", {30'd0, in_ready, out_valid}, 32'd2);
    chk("abt_nib0", {28'd0, nib_x}, 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      tick();
    end
    chk("abt_nores", n, 32'd0);
    chk("abt_flg", flags(), 32'b1010);

    run_op("sub_eq",  32'd5,        32'd5, 1'b1, 32'h00000000, 4'b1010);
    run_op("sub_brw", 32'd0,        32'd1, 1'b1, 32'hFFFFFFFF, 4'b0001);
    run_op("sub_ovf", 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 4'b1100);

    // Backpressure: DONE held, new requests ignored.
    a = 32'd3; b = 32'd4; sub = 1'b0; in_valid = 1'b1;
    tick();
    a = 32'hDEADBEEF; b = 32'h12345678;
    wait_done(n);
    chk("bp_lat", n, 32'd8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {30'd0, in_ready, out_valid}, 32'd1);
      chk("bp_res", result, 32'd7);
      chk("bp_flg", flags(), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_xfer", {30'd0, in_ready, out_valid}, 32'd2);
    chk("bp_res2", result, 32'd7);

    // Reset at idx=5 returns everything to reset values immediately.
    a = 32'h11111111; b = 32'h11111111; sub = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mrst_hs", {30'd0, in_ready, out_valid}, 32'd2);
    chk("mrst_res", result, 32'd0);
    chk("mrst_flg", flags(), 32'd0);
    chk("mrst_nib", {23'd0, nib_x, nib_y, nib_cin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_op("post", 32'd1, 32'd2, 1'b0, 32'd3, 4'b0000);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    a = 32'd100; b = 32'd23; sub = 1'b0; in_valid = 1'b1;
    tick();
    a = 32'd50; b = 32'd8; sub = 1'b1;
    n = 0;
    while (n < 30) begin
      tick();
      n++;
      if (out_valid) begin
        chk("b2b_res1", result, 32'd123);
        chk("b2b_nib", {23'd0, nib_x, nib_y, nib_cin}, 32'd0);
      end
      if (in_ready) break;
    end
    tick();
    n++;
    chk("b2b_int", n, 32'd10);
    chk("b2b_acc", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_done(n);
    chk("b2b_lat2", n, 32'd8);
    chk("b2b_res2", result, 32'd42);
    tick();
    chk("b2b_idle", {30'd0, in_ready, out_valid}, 32'd2);
    chk("b2b_nib0", {23'd0, nib_x, nib_y, nib_cin}, 32'd0);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit add/subtract sequencer that drives a single external 4-bit carry-lookahead nibble adder. It sits directly upstream and downstream of that adder in the CPU datapath. Each cycle it presents one operand nibble pair plus the running carry, then captures the nibble sum and carry-out into a result register. It trades latency for area and reports carry, overflow, zero and negative flags to the ALU control.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 8; N = WIDTH/4 nibbles.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- a  in  WIDTH  operand A; sampled on accept.
- b  in  WIDTH  operand B; sampled on accept.
- sub  in  1  1 = A − B, 0 = A + B; sampled on accept.
- abort  in  1  synchronous cancel; returns the block to IDLE.
- out_valid  out  1  result and flags are valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference.
- cout  out  1  final carry-out; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- nib_x  out  4  nibble of A to the adder.
- nib_y  out  4  nibble of B' to the adder.
- nib_cin  out  1  carry-in to the adder.
- nib_s  in  4  adder sum, combinational from nib_x, nib_y and nib_cin.
- nib_cout  in  1  adder carry-out.

## Operation
- States: IDLE, RUN, DONE. Registers:
  - a_r, b_r: WIDTH bits.
  - carry_r: 1 bit.
  - idx: ceil(log2 N) bits.
  - res_r: WIDTH bits.
  - Flag registers.
- IDLE:
  - in_ready=1.
  - On in_valid: a_r←a; b_r←(sub ? ~b : b); carry_r←sub; idx←0; go to RUN.
- RUN:
  - nib_x = a_r[4*idx+3:4*idx]; nib_y = b_r[4*idx+3:4*idx]; nib_cin = carry_r.
  - Each cycle: res_r[4*idx+3:4*idx]←nib_s; carry_r←nib_cout; idx←idx+1.
  - On the cycle with idx==N−1, also latch the flags and go to DONE:
    - cout←nib_cout.
    - neg←nib_s[3].
    - ovf←(a_r[W−1]==b_r[W−1]) && (nib_s[3]!=a_r[W−1]).
    - zero←(final res_r==0), including the nibble written that cycle.
- DONE:
  - out_valid=1; result and flags are held stable.
  - On out_ready: go to IDLE.
- Outside RUN, nib_x, nib_y and nib_cin are driven 0.
- abort has priority over all transitions: next state IDLE, out_valid drops, res_r and flags keep their old values, and no result is delivered.
- Flags are registered. They change only on the final RUN cycle.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, cout=ovf=zero=neg=0, nib_*=0, idx=0, carry_r=0.
- Reset is asynchronous and may occur in any state, including mid-RUN. The block returns to IDLE immediately; the partial result is discarded.
- Latency: accept at edge k; RUN occupies cycles k+1..k+N; out_valid is high from the cycle after edge k+N.
  - For WIDTH=32, out_valid is high 8 cycles after the accept edge.
- If out_ready is already high, the transfer happens at edge k+N+1 and in_ready returns the following cycle.
- Minimum issue interval is N+2 cycles.
- in_ready=0 throughout RUN and DONE. in_valid is ignored there; a and b may change freely.
- Backpressure: DONE is held indefinitely while out_ready=0.
- Adder path: the nib_x/nib_y/nib_cin → nib_s/nib_cout loop must settle within one clock period. There is no pipeline register inside the adder.
- idx does not wrap during operation. It is reloaded to 0 on every accept.

## Test plan
- Add with carry ripple: a=0x0000FFFF, b=0x00000001, sub=0, WIDTH=32 → result=0x00010000, cout=0, ovf=0, zero=0, neg=0. out_valid rises exactly 8 cycles after the accept edge.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 → result=0x80000000, ovf=1, neg=1, cout=0. Also a=0xFFFFFFFF, b=0x00000001, sub=0 → result=0, cout=1, zero=1, ovf=0.
- Subtract: a=5, b=5, sub=1 → result=0, zero=1, cout=1. Then a=0, b=1, sub=1 → result=0xFFFFFFFF, cout=0, neg=1, ovf=0. Then a=0x80000000, b=1, sub=1 → result=0x7FFFFFFF, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result and flags stay stable, in_ready=0, and a new in_valid is not accepted. Raise out_ready → one transfer, then in_ready=1.
- Abort and reset: assert abort while idx=3 → next cycle state=IDLE, out_valid=0, in_ready=1, and no result is delivered. Assert rst while idx=5 → all outputs return immediately to their reset values. A following operation 1+2 produces 3.
- Back-to-back: two operations, each issued as soon as in_ready is high, with out_ready tied to 1 → results delivered in order with issue interval N+2=10 cycles. nib_* is 0 outside RUN.
